// File: rtl/execute_md.sv
// ============================================================================
// Module   : execute_md
// Purpose  : MIPS execute stage - ALU, background iterative mult/div, HI/LO
//            registers and the ID->EX pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module execute_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             AnyStall,
    input  logic             AluSrc_ID,
    input  logic [3:0]       AluControl_ID,
    input  logic [2:0]       MdOp_ID,
    input  logic [15:0]      Imm_ID,
    input  logic             RegWrite_ID,
    input  logic             MemWrite_ID,
    input  logic             MemToReg_ID,
    input  logic [WIDTH-1:0] RdDatA_ID,
    input  logic [WIDTH-1:0] RdDatB_ID,
    output logic [WIDTH-1:0] Result_EX,
    output logic             RegWrite_EX,
    output logic             MemToReg_EX,
    output logic             MemWrite_EX,
    output logic             Stall_EX,
    output logic             MdBusy
);

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    md_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             regwrite_q, regwrite_d, memtoreg_q, memtoreg_d, memwrite_q, memwrite_d;

    logic [WIDTH-1:0] op_a, op_b, alu_res, ex_res;
    logic [SHW-1:0]   shamt;
    logic             md_op, uses_hilo, signed_op, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op_a      = RdDatA_ID;
    assign op_b      = AluSrc_ID ? WIDTH'(Imm_ID) : RdDatB_ID;
    assign shamt     = Imm_ID[SHW+5:6];
    assign md_op     = (MdOp_ID >= 3'd1) && (MdOp_ID <= 3'd4);
    assign uses_hilo = (MdOp_ID >= 3'd1) && (MdOp_ID <= 3'd6);
    assign signed_op = (MdOp_ID == 3'd1) || (MdOp_ID == 3'd3);
    assign neg_a     = signed_op && RdDatA_ID[WIDTH-1];
    assign neg_b     = signed_op && RdDatB_ID[WIDTH-1];
    assign mag_a     = neg_a ? -RdDatA_ID : RdDatA_ID;
    assign mag_b     = neg_b ? -RdDatB_ID : RdDatB_ID;

    assign MdBusy    = (state_q != ST_IDLE);
    assign Stall_EX  = MdBusy && uses_hilo;

    always_comb begin
        alu_res = '0;
        case (AluControl_ID)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0101: alu_res = op_a ^ op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0111: alu_res = {WIDTH{$signed(op_a) < $signed(op_b)}};
            4'b0011: alu_res = op_a << op_b[SHW-1:0];
            4'b0100: alu_res = op_a >> op_b[SHW-1:0];
            4'b1100: alu_res = op_b << shamt;
            4'b1101: alu_res = op_b >> shamt;
            4'b1110: alu_res = $unsigned($signed(op_b) >>> shamt);
            4'b1001: alu_res = op_b << 16;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        ex_res = alu_res;
        if (MdOp_ID == 3'd5)
            ex_res = hi_q;
        else if (MdOp_ID == 3'd6)
            ex_res = lo_q;
    end

    // One shift-add (mult) or restoring-subtract (div) step on {hi_part, lo_part}.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step, mul_fix, div_step;
    logic [WIDTH:0]       r_sh;
    logic                 div_ge;
    logic [WIDTH-1:0]     quot, rem;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_fix  = (neg_a_q ^ neg_b_q) ? -mul_step : mul_step;
    assign r_sh     = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = r_sh >= {1'b0, opb_q};
    assign div_step = div_ge ? {r_sh[WIDTH-1:0] - opb_q, acc_q[WIDTH-2:0], 1'b1}
                             : {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    assign quot     = div_step[WIDTH-1:0];
    assign rem      = div_step[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (md_op && !AnyStall && !flush) begin
                    state_d = (MdOp_ID <= 3'd2) ? ST_MUL : ST_DIV;
                    cnt_d   = CNT_INIT;
                    acc_d   = {{WIDTH{1'b0}}, mag_a};
                    opb_d   = mag_b;
                    neg_a_d = neg_a;
                    neg_b_d = neg_b;
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = (state_q == ST_MUL) ? mul_step : div_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_IDLE;
                        if (state_q == ST_MUL) begin
                            hi_d = mul_fix[2*WIDTH-1:WIDTH];
                            lo_d = mul_fix[WIDTH-1:0];
                        end else begin
                            // A zero divisor leaves the dividend in the remainder;
                            // only the quotient needs forcing to all ones.
                            lo_d = (opb_q == '0) ? {WIDTH{1'b1}}
                                 : ((neg_a_q ^ neg_b_q) ? -quot : quot);
                            hi_d = neg_a_q ? -rem : rem;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        result_d   = result_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        memwrite_d = memwrite_q;
        if (flush) begin
            result_d   = '0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            memwrite_d = 1'b0;
        end else if (!(AnyStall || Stall_EX)) begin
            result_d   = ex_res;
            regwrite_d = RegWrite_ID && !md_op;
            memtoreg_d = MemToReg_ID;
            memwrite_d = MemWrite_ID;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            result_q   <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memwrite_q <= memwrite_d;
        end
    end

    assign Result_EX   = result_q;
    assign RegWrite_EX = regwrite_q;
    assign MemToReg_EX = memtoreg_q;
    assign MemWrite_EX = memwrite_q;

endmodule

`default_nettype wire

// File: tb/tb_execute_md.sv
// ============================================================================
// Module   : tb_execute_md
// Purpose  : Directed self-checking bench for execute_md (32- and 16-bit).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_execute_md;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush, any_stall, alu_src, rw, mw, m2r;
    logic [3:0]  alu_ctl;
    logic [2:0]  md_op;
    logic [15:0] imm;
    logic [31:0] a, b;
    logic [31:0] res;
    logic        rw_ex, m2r_ex, mw_ex, stall_ex, busy;

    logic [3:0]  ctl16;
    logic [2:0]  md16;
    logic [15:0] a16, b16, res16;
    logic        rw16_ex, m2r16_ex, mw16_ex, stall16, busy16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_md #(.WIDTH(32), .SHW(5)) u32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .AnyStall(any_stall),
        .AluSrc_ID(alu_src), .AluControl_ID(alu_ctl), .MdOp_ID(md_op), .Imm_ID(imm),
        .RegWrite_ID(rw), .MemWrite_ID(mw), .MemToReg_ID(m2r),
        .RdDatA_ID(a), .RdDatB_ID(b), .Result_EX(res),
        .RegWrite_EX(rw_ex), .MemToReg_EX(m2r_ex), .MemWrite_EX(mw_ex),
        .Stall_EX(stall_ex), .MdBusy(busy)
    );

    execute_md #(.WIDTH(16), .SHW(4)) u16 (
        .clk(clk), .reset_n(reset_n), .flush(1'b0), .AnyStall(1'b0),
        .AluSrc_ID(1'b0), .AluControl_ID(ctl16), .MdOp_ID(md16), .Imm_ID(16'h0000),
        .RegWrite_ID(1'b1), .MemWrite_ID(1'b0), .MemToReg_ID(1'b0),
        .RdDatA_ID(a16), .RdDatB_ID(b16), .Result_EX(res16),
        .RegWrite_EX(rw16_ex), .MemToReg_EX(m2r16_ex), .MemWrite_EX(mw16_ex),
        .Stall_EX(stall16), .MdBusy(busy16)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [2:0] md,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [15:0] vimm, input logic src,
                         input logic vrw, input logic vmw, input logic vm2r);
        alu_ctl = ctl; md_op = md; a = va; b = vb; imm = vimm;
        alu_src = src; rw = vrw; mw = vmw; m2r = vm2r;
    endtask

    task automatic nop;
        drive(4'b0000, 3'd0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick;
            n++;
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        drive(4'b0000, 3'd5, 32'h0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        hi = res;
        drive(4'b0000, 3'd6, 32'h0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        lo = res;
        nop;
    endtask

    task automatic test_reset;
        int n;
        logic [31:0] hi, lo;
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp %h", res, 32'h0); end
        checks++; if ({rw_ex, m2r_ex, mw_ex, busy} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b exp %b", {rw_ex, m2r_ex, mw_ex, busy}, 4'b0); end
        drive(4'b0000, 3'd1, 32'hFFFFFFFD, 32'd5, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        nop;
        wait_idle(n);
        drive(4'b0000, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        drive(4'b0010, 3'd0, 32'd7, 32'd5, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick;
        reset_n = 1'b0;
        #1;
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL midreset_result got %h exp %h", res, 32'h0); end
        checks++; if ({rw_ex, m2r_ex, mw_ex, busy, stall_ex} !== 5'b0) begin errors++; $display("FAIL midreset_ctrl got %b exp %b", {rw_ex, m2r_ex, mw_ex, busy, stall_ex}, 5'b0); end
        nop;
        tick;
        reset_n = 1'b1;
        read_hilo(hi, lo);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp %h", lo, 32'h0); end
    endtask

    task automatic test_alu;
        drive(4'b0010, 3'd0, 32'd7, 32'd5, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL add got %h exp %h", res, 32'd12); end
        checks++; if (rw_ex !== 1'b1) begin errors++; $display("FAIL add_regwrite got %b exp %b", rw_ex, 1'b1); end
        drive(4'b0110, 3'd0, 32'd3, 32'd5, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub got %h exp %h", res, 32'hFFFFFFFE); end
        drive(4'b1110, 3'd0, 32'h80000000, 32'h80000000, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (res !== 32'hF8000000) begin errors++; $display("FAIL sra got %h exp %h", res, 32'hF8000000); end
        drive(4'b1001, 3'd0, 32'h0, 32'h0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (res !== 32'h12340000) begin errors++; $display("FAIL lui got %h exp %h", res, 32'h12340000); end
        drive(4'b0101, 3'd0, 32'h0000F0F0, 32'h00000FF0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (res !== 32'h0000FF00) begin errors++; $display("FAIL xor got %h exp %h", res, 32'h0000FF00); end
        drive(4'b0011, 3'd0, 32'd1, 32'h00000024, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (res !== 32'h00000010) begin errors++; $display("FAIL sllv got %h exp %h", res, 32'h00000010); end
        drive(4'b1100, 3'd0, 32'd1, 32'd1, 16'h07C0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (res !== 32'h80000000) begin errors++; $display("FAIL sll31 got %h exp %h", res, 32'h80000000); end
        drive(4'b1111, 3'd0, 32'd5, 32'd5, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL badop got %h exp %h", res, 32'h0); end
        nop;
    endtask

    task automatic test_mult;
        int n;
        logic [31:0] hi, lo;
        drive(4'b0000, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        checks++; if (rw_ex !== 1'b0) begin errors++; $display("FAIL mult_regwrite got %b exp %b", rw_ex, 1'b0); end
        nop;
        wait_idle(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL multu_busy_cycles got %0d exp %0d", n, 32); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp %h", hi, 32'hFFFFFFFE); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp %h", lo, 32'h00000001); end
        drive(4'b0000, 3'd1, 32'hFFFFFFFD, 32'd5, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        nop;
        wait_idle(n);
        read_hilo(hi, lo);
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp %h", hi, 32'hFFFFFFFF); end
        checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h exp %h", lo, 32'hFFFFFFF1); end
    endtask

    task automatic test_div;
        int n;
        logic [31:0] hi, lo;
        logic [2:0]  ops [4]  = '{3'd3, 3'd4, 3'd3, 3'd3};
        logic [31:0] dvd [4]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] dvs [4]  = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
        logic [31:0] ehi [4]  = '{32'hFFFFFFFF, 32'd7, 32'h0, 32'hFFFFFFF9};
        logic [31:0] elo [4]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            drive(4'b0000, ops[i], dvd[i], dvs[i], 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick;
            nop;
            wait_idle(n);
            read_hilo(hi, lo);
            checks++; if (lo !== elo[i]) begin errors++; $display("FAIL div%0d_lo got %h exp %h", i, lo, elo[i]); end
            checks++; if (hi !== ehi[i]) begin errors++; $display("FAIL div%0d_hi got %h exp %h", i, hi, ehi[i]); end
        end
    endtask

    task automatic test_hazard;
        int n;
        drive(4'b0000, 3'd1, 32'hFFFFFFFF, 32'd2, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        nop;
        tick;
        drive(4'b0000, 3'd5, 32'h0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        n = 0;
        while (stall_ex && n < 100) begin
            tick;
            n++;
        end
        checks++; if (n !== 31) begin errors++; $display("FAIL hazard_stall_cycles got %0d exp %0d", n, 31); end
        tick;
        checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL hazard_mfhi got %h exp %h", res, 32'hFFFFFFFF); end
        checks++; if (rw_ex !== 1'b1) begin errors++; $display("FAIL hazard_regwrite got %b exp %b", rw_ex, 1'b1); end
        drive(4'b0000, 3'd2, 32'hFFFFFFFF, 32'd3, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        drive(4'b0010, 3'd0, 32'd10, 32'd20, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (stall_ex !== 1'b0) begin errors++; $display("FAIL indep_stall got %b exp %b", stall_ex, 1'b0); end
        tick;
        checks++; if (res !== 32'd30) begin errors++; $display("FAIL indep_add got %h exp %h", res, 32'd30); end
        nop;
        wait_idle(n);
    endtask

    task automatic test_flush;
        int n;
        logic [31:0] hi, lo;
        drive(4'b0000, 3'd2, 32'd5, 32'd5, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        nop;
        repeat (9) tick;
        drive(4'b0010, 3'd0, 32'd1, 32'd1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        nop;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp %b", busy, 1'b0); end
        checks++; if ({res, rw_ex, mw_ex, m2r_ex} !== 35'h0) begin errors++; $display("FAIL flush_ex got %h exp %h", {res, rw_ex, mw_ex, m2r_ex}, 35'h0); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL flush_hi got %h exp %h", hi, 32'd2); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL flush_lo got %h exp %h", lo, 32'hFFFFFFFD); end
        drive(4'b0000, 3'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        nop;
        wait_idle(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL restart_cycles got %0d exp %0d", n, 32); end
        read_hilo(hi, lo);
        checks++; if ({hi, lo} !== 64'h6) begin errors++; $display("FAIL restart_hilo got %h exp %h", {hi, lo}, 64'h6); end
        drive(4'b0000, 3'd2, 32'd4, 32'd4, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        nop;
        repeat (31) tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lastcycle_busy got %b exp %b", busy, 1'b1); end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lastflush_busy got %b exp %b", busy, 1'b0); end
        read_hilo(hi, lo);
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL lastflush_lo got %h exp %h", lo, 32'd6); end
    endtask

    task automatic test_stall;
        drive(4'b0010, 3'd0, 32'd1, 32'd2, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick;
        checks++; if ({res, rw_ex, mw_ex, m2r_ex} !== {32'd3, 3'b110}) begin errors++; $display("FAIL prestall got %h exp %h", {res, rw_ex, mw_ex, m2r_ex}, {32'd3, 3'b110}); end
        drive(4'b0010, 3'd0, 32'd100, 32'd200, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        any_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if ({res, rw_ex, mw_ex, m2r_ex} !== {32'd3, 3'b110}) begin errors++; $display("FAIL stall_hold%0d got %h exp %h", i, {res, rw_ex, mw_ex, m2r_ex}, {32'd3, 3'b110}); end
        end
        any_stall = 1'b0;
        tick;
        checks++; if ({res, rw_ex, mw_ex, m2r_ex} !== {32'd300, 3'b001}) begin errors++; $display("FAIL poststall got %h exp %h", {res, rw_ex, mw_ex, m2r_ex}, {32'd300, 3'b001}); end
        nop;
    endtask

    task automatic test_width16;
        int n;
        ctl16 = 4'b0000; md16 = 3'd4; a16 = 16'd100; b16 = 16'd7;
        tick;
        md16 = 3'd0;
        n = 0;
        while (busy16 && n < 100) begin
            tick;
            n++;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL w16_cycles got %0d exp %0d", n, 16); end
        md16 = 3'd6;
        tick;
        checks++; if (res16 !== 16'd14) begin errors++; $display("FAIL w16_lo got %h exp %h", res16, 16'd14); end
        md16 = 3'd5;
        tick;
        checks++; if (res16 !== 16'd2) begin errors++; $display("FAIL w16_hi got %h exp %h", res16, 16'd2); end
        md16 = 3'd0; ctl16 = 4'b0010; a16 = 16'hFFFF; b16 = 16'd2;
        tick;
        checks++; if (res16 !== 16'd1) begin errors++; $display("FAIL w16_addwrap got %h exp %h", res16, 16'd1); end
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        any_stall = 1'b0;
        nop;
        ctl16 = 4'b0000; md16 = 3'd0; a16 = 16'h0; b16 = 16'h0;
        repeat (2) tick;
        reset_n = 1'b1;
        tick;
        test_reset;
        test_alu;
        test_mult;
        test_div;
        test_hazard;
        test_flush;
        test_stall;
        test_width16;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
